// File: rtl/mem_port_ctrl_pkg.sv
// ============================================================================
// mem_port_ctrl_pkg : shared sizes, FSM encodings and response record for
//                     the memory port controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_port_ctrl_pkg;

    localparam int HBIT_ADDR     = 11;
    localparam int HBIT_DATA     = 23;
    localparam int MEM_WORDS_DEF = 4096;

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    typedef struct packed {
        logic                 is_wr;
        logic [HBIT_DATA:0]   rdata;
    } rsp_t;

endpackage

`default_nettype wire

// File: rtl/mem_rsp_fifo.sv
// ============================================================================
// mem_rsp_fifo : synchronous response FIFO with push/pop/count/head and
//                asynchronous active-high reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_rsp_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               push_data_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               head_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W-1:0] rd_q;
    logic [CNT_W-1:0] cnt_q;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= next_ptr(wr_q);
            end
            if (pop_i) begin
                rd_q <= next_ptr(rd_q);
            end
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    // The credit check upstream makes both of these unreachable.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && !pop_i && (cnt_q == CNT_W'(DEPTH))));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(pop_i && (cnt_q == '0)));

endmodule

`default_nettype wire

// File: rtl/mem_port_ctrl.sv
// ============================================================================
// mem_port_ctrl : pipeline-side initiator for the single-port RAM with init
//                 sweep, credit-based response buffering and backpressure.
//                 Optional macro MEM_WACK_EN: stores return an ack response.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_ctrl
    import mem_port_ctrl_pkg::*;
#(
    parameter int               RSP_DEPTH  = 4,
    parameter int               INIT_SWEEP = 1,
    parameter int               MEM_WORDS  = MEM_WORDS_DEF,
    parameter logic [HBIT_DATA:0] INIT_VAL = '0
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst,
    input  logic                 iw_req_valid,
    output logic                 ow_req_ready,
    input  logic                 iw_req_we,
    input  logic [HBIT_ADDR:0]   iw_req_addr,
    input  logic [HBIT_DATA:0]   iw_req_wdata,
    output logic                 ow_rsp_valid,
    input  logic                 iw_rsp_ready,
    output logic [HBIT_DATA:0]   ow_rsp_rdata,
    output logic                 ow_rsp_is_wr,
    output logic                 ow_init_done,
    output logic                 ow_mem_we,
    output logic [HBIT_ADDR:0]   ow_mem_addr,
    output logic [HBIT_DATA:0]   ow_mem_wdata,
    input  logic [HBIT_DATA:0]   iw_mem_rdata
);

    localparam int               AW        = HBIT_ADDR + 1;
    localparam int               CNT_W     = $clog2(RSP_DEPTH + 1);
    localparam logic [AW-1:0]    LAST_ADDR = AW'(MEM_WORDS - 1);
    localparam logic [0:0]       RST_STATE = (INIT_SWEEP != 0) ? S_INIT : S_RUN;

    logic [0:0]     state_q, state_d;
    logic [AW-1:0]  ctr_q, ctr_d;
    logic           infl_q, infl_d;
    logic [CNT_W-1:0] fifo_cnt;
    logic [CNT_W:0] credits_used;
    rsp_t           fifo_head;
    rsp_t           fifo_push_data;
    logic           sweep;
    logic           accept;
    logic           needs_rsp;
    logic           pop;

    assign sweep        = (state_q == S_INIT) && !iw_rst;
    assign credits_used = {{CNT_W{1'b0}}, infl_q} + {1'b0, fifo_cnt};
    assign ow_req_ready = (state_q == S_RUN) && !iw_rst &&
                          (credits_used < (CNT_W + 1)'(RSP_DEPTH));
    assign accept       = iw_req_valid && ow_req_ready;
    assign ow_init_done = (state_q == S_RUN);

`ifdef MEM_WACK_EN
    logic infl_wr_q;
    assign needs_rsp = 1'b1;
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) infl_wr_q <= 1'b0;
        else        infl_wr_q <= accept && iw_req_we;
    end
    assign fifo_push_data = '{is_wr: infl_wr_q, rdata: iw_mem_rdata};
`else
    assign needs_rsp      = !iw_req_we;
    assign fifo_push_data = '{is_wr: 1'b0, rdata: iw_mem_rdata};
`endif

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        infl_d  = accept && needs_rsp;
        if (state_q == S_INIT) begin
            ctr_d = ctr_q + 1'b1;
            if (ctr_q == LAST_ADDR) begin
                state_d = S_RUN;
            end
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state_q <= RST_STATE;
            ctr_q   <= '0;
            infl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            infl_q  <= infl_d;
        end
    end

    // RAM port: sweep owns it during init, otherwise only an accepted request drives it.
    always_comb begin
        ow_mem_we    = 1'b0;
        ow_mem_addr  = '0;
        ow_mem_wdata = '0;
        if (sweep) begin
            ow_mem_we    = 1'b1;
            ow_mem_addr  = ctr_q;
            ow_mem_wdata = INIT_VAL;
        end else if (accept) begin
            ow_mem_we    = iw_req_we;
            ow_mem_addr  = iw_req_addr;
            ow_mem_wdata = iw_req_wdata;
        end
    end

    assign ow_rsp_valid = (fifo_cnt != '0);
    assign pop          = ow_rsp_valid && iw_rsp_ready;
    assign ow_rsp_rdata = fifo_head.rdata;
    assign ow_rsp_is_wr = fifo_head.is_wr;

    mem_rsp_fifo #(
        .WIDTH (HBIT_DATA + 2),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i       (iw_clk),
        .rst_i       (iw_rst),
        .push_i      (infl_q),
        .push_data_i (fifo_push_data),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .count_o     (fifo_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_port_ctrl.sv
// ============================================================================
// tb_mem_port_ctrl : self-checking bench for mem_port_ctrl with a RAM model and
//                    a queue-based reference of the response channel.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_ctrl;
    import mem_port_ctrl_pkg::*;

    localparam int DEPTH = 4;
    localparam int WORDS = 16;
`ifdef MEM_WACK_EN
    localparam bit WACK = 1'b1;
`else
    localparam bit WACK = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid, req_ready, req_we;
    logic [HBIT_ADDR:0] req_addr;
    logic [HBIT_DATA:0] req_wdata;
    logic               rsp_valid, rsp_ready, rsp_is_wr, init_done;
    logic [HBIT_DATA:0] rsp_rdata;
    logic               mem_we;
    logic [HBIT_ADDR:0] mem_addr;
    logic [HBIT_DATA:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_ctrl #(
        .RSP_DEPTH (DEPTH),
        .INIT_SWEEP(1),
        .MEM_WORDS (WORDS),
        .INIT_VAL  (24'h0)
    ) dut (
        .iw_clk      (clk),
        .iw_rst      (rst),
        .iw_req_valid(req_valid),
        .ow_req_ready(req_ready),
        .iw_req_we   (req_we),
        .iw_req_addr (req_addr),
        .iw_req_wdata(req_wdata),
        .ow_rsp_valid(rsp_valid),
        .iw_rsp_ready(rsp_ready),
        .ow_rsp_rdata(rsp_rdata),
        .ow_rsp_is_wr(rsp_is_wr),
        .ow_init_done(init_done),
        .ow_mem_we   (mem_we),
        .ow_mem_addr (mem_addr),
        .ow_mem_wdata(mem_wdata),
        .iw_mem_rdata(mem_rdata)
    );

    // Read-first synchronous RAM seen by the DUT.
    logic [HBIT_DATA:0] ram [0:4095];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: every accepted request needing a response is an entry that becomes
    // visible two cycles later and leaves when consumed.
    typedef struct {
        logic [HBIT_DATA:0] data;
        bit                 wr;
        int                 avail;
    } exp_t;

    exp_t               q[$];
    logic [HBIT_DATA:0] mdl [0:4095];
    int                 sw  = 0;
    int                 cyc = 0;
    int                 last_acc_cyc = 0;
    logic [HBIT_DATA:0] pop_data[$];
    bit                 pop_wr[$];
    int                 pop_cyc[$];
    bit                 e_ready, e_valid, acc;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_valid", rsp_valid, 0);
            chk("rst_done",  init_done, 0);
            q.delete();
            sw = 0;
        end else if (sw < WORDS) begin
            chk("sweep_we",    mem_we, 1);
            chk("sweep_addr",  mem_addr, sw);
            chk("sweep_wdata", mem_wdata, 0);
            chk("sweep_ready", req_ready, 0);
            chk("sweep_done",  init_done, 0);
            chk("sweep_valid", rsp_valid, 0);
            mdl[sw] = '0;
            sw++;
        end else begin
            e_ready = (q.size() < DEPTH);
            e_valid = (q.size() > 0) && (q[0].avail <= cyc);
            chk("run_done",  init_done, 1);
            chk("req_ready", req_ready, e_ready);
            chk("rsp_valid", rsp_valid, e_valid);
            if (e_valid) begin
                chk("rsp_rdata", rsp_rdata, q[0].data);
                chk("rsp_is_wr", rsp_is_wr, q[0].wr);
            end
            acc = req_valid && e_ready;
            if (acc) begin
                chk("mem_we",    mem_we, req_we);
                chk("mem_addr",  mem_addr, req_addr);
                chk("mem_wdata", mem_wdata, req_wdata);
            end else begin
                chk("idle_we",    mem_we, 0);
                chk("idle_addr",  mem_addr, 0);
                chk("idle_wdata", mem_wdata, 0);
            end
            if (e_valid && rsp_ready) begin
                pop_data.push_back(q[0].data);
                pop_wr.push_back(q[0].wr);
                pop_cyc.push_back(cyc);
                void'(q.pop_front());
            end
            if (acc) begin
                last_acc_cyc = cyc;
                if (!req_we || WACK) q.push_back('{mdl[req_addr], req_we, cyc + 2});
                if (req_we) mdl[req_addr] = req_wdata;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit we, input int a, input logic [HBIT_DATA:0] d);
        bit got = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = HBIT_ADDR'(a) ; req_wdata = d;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            got = req_ready;
            tick();
            if (got) break;
        end
        if (!got) chk("send_timeout", 0, 1);
        req_valid = 1'b0;
    endtask

    task automatic sweep_check();
        int k = 0;
        int n = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (init_done) begin seen = 1'b1; break; end
            k++;
            if (mem_we) n++;
        end
        chk("sweep_seen",   seen, 1);
        chk("sweep_cycles", k, 16);
        chk("sweep_we_cnt", n, 16);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, k, acc0;
        for (int i = 0; i < 4096; i++) ram[i] = 24'($urandom);
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        sweep_check();

        // Store then load, same address.
        send(1'b1, 5, 24'hABCDEF);
        send(1'b0, 5, 24'h0);
        acc0 = last_acc_cyc;
        repeat (4) tick();
        chk("st_ld_data", pop_data[pop_data.size()-1], 24'hABCDEF);
        chk("st_ld_lat",  pop_cyc[pop_cyc.size()-1] - acc0, 2);

        // Preload then 8 back-to-back loads.
        for (int i = 0; i < 8; i++) send(1'b1, i, 24'h100 + 24'(i));
        repeat (4) tick();
        req_valid = 1'b1; req_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_addr = HBIT_ADDR'(i);
            @(negedge clk);
            chk("burst_ready", req_ready, 1);
            tick();
        end
        req_valid = 1'b0;
        repeat (4) tick();
        n0 = pop_data.size() - 8;
        for (int i = 0; i < 8; i++) begin
            chk("burst_data", pop_data[n0+i], 24'h100 + 24'(i));
            if (i > 0) chk("burst_consec", pop_cyc[n0+i] - pop_cyc[n0+i-1], 1);
        end

        // Backpressure: exactly DEPTH loads fit, then all drain in order.
        rsp_ready = 1'b0; k = 0;
        req_valid = 1'b1; req_we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req_addr = HBIT_ADDR'(i);
            @(negedge clk);
            if (req_ready) k++;
            tick();
        end
        req_valid = 1'b0;
        chk("bp_accepts", k, DEPTH);
        repeat (3) tick();
        n0 = pop_data.size();
        rsp_ready = 1'b1;
        repeat (8) tick();
        chk("bp_drain", pop_data.size() - n0, DEPTH);
        for (int i = 0; i < DEPTH; i++) chk("bp_order", pop_data[n0+i], 24'h100 + 24'(i));

        // Reset with two buffered responses and one in flight.
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_addr = HBIT_ADDR'(i);
            tick();
        end
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_valid_now", rsp_valid, 0);
        tick(); tick();
        rst = 1'b0;
        sweep_check();
        n0 = pop_data.size();
        rsp_ready = 1'b1;
        repeat (6) tick();
        chk("no_stale", pop_data.size() - n0, 0);

        // Store over an existing word.
        send(1'b1, 3, 24'h77);
        repeat (4) tick();
        n0 = pop_data.size();
        send(1'b1, 3, 24'h1);
        repeat (4) tick();
`ifdef MEM_WACK_EN
        chk("wack_cnt",   pop_data.size() - n0, 1);
        chk("wack_data",  pop_data[pop_data.size()-1], 24'h77);
        chk("wack_is_wr", pop_wr[pop_wr.size()-1], 1);
`else
        chk("no_wack", pop_data.size() - n0, 0);
`endif

        // Random traffic over a small address window to force collisions.
        for (int i = 0; i < 500; i++) begin
            req_valid = ($urandom_range(0, 9) < 6);
            req_we    = ($urandom_range(0, 9) < 4);
            req_addr  = HBIT_ADDR'($urandom_range(0, 15));
            req_wdata = 24'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (10) tick();
        chk("final_empty", rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
